// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for CPU core run control; the AXI controller's status register map reuses them.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RSTSEQ = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        OP_HALT       = 2'd0,
        OP_RUN        = 2'd1,
        OP_STEP       = 2'd2,
        OP_RESET_CORE = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        CAUSE_RESET     = 2'd0,
        CAUSE_HOST_HALT = 2'd1,
        CAUSE_STEP_DONE = 2'd2,
        CAUSE_BREAKPT   = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/cpu_core_run_control.sv
// Run/halt/step sequencer: drives CPU core reset and clock enable, watches the
// hardware breakpoint and counts executed cycles for the debug window.
module cpu_core_run_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_WIDTH  = 64
) (
    input  logic                 CCLK,
    input  logic                 CRST,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [1:0]           CMD_OP,
    input  logic [31:0]          CMD_ARG,
    input  logic                 BP_EN,
    input  logic [31:0]          BP_ADDR,
    input  logic [31:0]          REGPC,
    output logic                 CORE_RST,
    output logic                 CORE_EN,
    output logic [1:0]           STATE,
    output logic [1:0]           HALT_CAUSE,
    output logic [31:0]          STEP_REMAIN,
    output logic [CNT_WIDTH-1:0] CYCLE_CNT
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_e          r_state;
    logic [RC_W-1:0]     r_rst_cnt;
    halt_cause_e         r_cause;
    logic [31:0]         r_step_remain;
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic                r_first;

    run_state_e          w_state_nxt;
    logic [RC_W-1:0]     w_rst_cnt_nxt;
    halt_cause_e         w_cause_nxt;
    logic [31:0]         w_step_remain_nxt;
    logic [CNT_WIDTH-1:0] w_cycle_cnt_nxt;
    logic                w_first_nxt;

    logic                w_accept;
    logic                w_bp_hit;
    logic                w_active;
    logic                w_cmd_reset;
    logic                w_cmd_halt;
    cmd_op_e             w_op;

    assign w_op        = cmd_op_e'(CMD_OP);
    assign w_active    = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign CMD_READY   = (r_state != ST_RSTSEQ);
    assign CORE_RST    = (r_state == ST_RSTSEQ);
    assign w_accept    = CMD_VALID && CMD_READY;
    assign w_cmd_reset = w_accept && (w_op == OP_RESET_CORE);
    assign w_cmd_halt  = w_accept && (w_op == OP_HALT);
    // The first-cycle mask lets the core step off a PC that equals BP_ADDR.
    assign w_bp_hit    = BP_EN && (REGPC == BP_ADDR) && !r_first;
    assign CORE_EN     = w_active && !w_bp_hit;

    assign STATE       = r_state;
    assign HALT_CAUSE  = r_cause;
    assign STEP_REMAIN = r_step_remain;
    assign CYCLE_CNT   = r_cycle_cnt;

    always_ff @(posedge CCLK) begin
        if (CRST) begin
            r_state       <= ST_RSTSEQ;
            r_rst_cnt     <= '0;
            r_cause       <= CAUSE_RESET;
            r_step_remain <= '0;
            r_cycle_cnt   <= '0;
            r_first       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rst_cnt     <= w_rst_cnt_nxt;
            r_cause       <= w_cause_nxt;
            r_step_remain <= w_step_remain_nxt;
            r_cycle_cnt   <= w_cycle_cnt_nxt;
            r_first       <= w_first_nxt;
        end
    end

    // Next-state: RESET_CORE > HALT > breakpoint > step completion.
    always_comb begin
        w_state_nxt       = r_state;
        w_rst_cnt_nxt     = r_rst_cnt;
        w_cause_nxt       = r_cause;
        w_step_remain_nxt = r_step_remain;
        w_cycle_cnt_nxt   = r_cycle_cnt + CNT_WIDTH'(CORE_EN);
        w_first_nxt       = 1'b0;

        if (w_cmd_reset) begin
            w_state_nxt     = ST_RSTSEQ;
            w_rst_cnt_nxt   = '0;
            w_cycle_cnt_nxt = '0;
            w_cause_nxt     = CAUSE_RESET;
        end else begin
            case (r_state)
                ST_RSTSEQ: begin
                    w_rst_cnt_nxt = r_rst_cnt + RC_W'(1);
                    if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        w_state_nxt = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (w_accept && (w_op == OP_RUN)) begin
                        w_state_nxt = ST_RUN;
                        w_first_nxt = 1'b1;
                    end else if (w_accept && (w_op == OP_STEP) && (CMD_ARG != 32'd0)) begin
                        w_state_nxt       = ST_STEP;
                        w_step_remain_nxt = CMD_ARG;
                        w_first_nxt       = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_cmd_halt) begin
                        w_state_nxt = ST_HALTED;
                        w_cause_nxt = CAUSE_HOST_HALT;
                    end else if (w_bp_hit) begin
                        w_state_nxt = ST_HALTED;
                        w_cause_nxt = CAUSE_BREAKPT;
                    end
                end
                ST_STEP: begin
                    if (w_cmd_halt) begin
                        w_state_nxt = ST_HALTED;
                        w_cause_nxt = CAUSE_HOST_HALT;
                    end else if (w_bp_hit) begin
                        w_state_nxt = ST_HALTED;
                        w_cause_nxt = CAUSE_BREAKPT;
                    end else if (r_step_remain == 32'd1) begin
                        w_state_nxt       = ST_HALTED;
                        w_cause_nxt       = CAUSE_STEP_DONE;
                        w_step_remain_nxt = '0;
                    end else begin
                        w_step_remain_nxt = r_step_remain - 32'd1;
                    end
                end
                default: w_state_nxt = ST_RSTSEQ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_run_control.sv
// Directed bench for cpu_core_run_control: reset sequencing, stepping,
// breakpoint halt/resume, halt priority and core reset during a step.
module tb_cpu_core_run_control;

    logic        CCLK = 1'b0;
    logic        CRST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [31:0] CMD_ARG;
    logic        BP_EN;
    logic [31:0] BP_ADDR;
    logic [31:0] REGPC;
    logic        CORE_RST;
    logic        CORE_EN;
    logic [1:0]  STATE;
    logic [1:0]  HALT_CAUSE;
    logic [31:0] STEP_REMAIN;
    logic [63:0] CYCLE_CNT;

    logic [31:0] pc;
    logic        pc_load;
    logic [31:0] pc_init;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_cnt;

    cpu_core_run_control #(.RST_CYCLES(4), .CNT_WIDTH(64)) dut (
        .CCLK        (CCLK),
        .CRST        (CRST),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_OP      (CMD_OP),
        .CMD_ARG     (CMD_ARG),
        .BP_EN       (BP_EN),
        .BP_ADDR     (BP_ADDR),
        .REGPC       (REGPC),
        .CORE_RST    (CORE_RST),
        .CORE_EN     (CORE_EN),
        .STATE       (STATE),
        .HALT_CAUSE  (HALT_CAUSE),
        .STEP_REMAIN (STEP_REMAIN),
        .CYCLE_CNT   (CYCLE_CNT)
    );

    always #5 CCLK = ~CCLK;

    // Core PC model: advances by 4 on every enabled edge.
    always @(posedge CCLK) begin
        if (pc_load) pc <= pc_init;
        else if (CORE_EN) pc <= pc + 32'd4;
    end
    assign REGPC = pc;

    task automatic nxt();
        @(posedge CCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ARG   = arg;
    endtask

    initial begin
        CRST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_ARG = 32'd0;
        BP_EN = 1'b0; BP_ADDR = 32'd0; pc_load = 1'b1; pc_init = 32'd0;

        // Reset: CRST high for 3 edges
        repeat (3) nxt();
        chk("rst_state",   64'(STATE), 64'd0);
        chk("rst_corerst", 64'(CORE_RST), 64'd1);
        chk("rst_ready",   64'(CMD_READY), 64'd0);
        chk("rst_coreen",  64'(CORE_EN), 64'd0);
        chk("rst_cause",   64'(HALT_CAUSE), 64'd0);
        chk("rst_remain",  64'(STEP_REMAIN), 64'd0);
        chk("rst_cycle",   CYCLE_CNT, 64'd0);
        CRST = 1'b0; pc_load = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rstseq_corerst", 64'(CORE_RST), 64'd1);
            chk("rstseq_ready",   64'(CMD_READY), 64'd0);
            nxt();
        end
        chk("rel_corerst", 64'(CORE_RST), 64'd0);
        chk("rel_state",   64'(STATE), 64'd1);
        chk("rel_cause",   64'(HALT_CAUSE), 64'd0);
        chk("rel_ready",   64'(CMD_READY), 64'd1);

        // STEP 5 from HALTED
        cmd(2'd2, 32'd5);
        nxt();
        CMD_VALID = 1'b0;
        #1;
        chk("step_state", 64'(STATE), 64'd3);
        en_cnt = 0;
        for (int i = 0; i < 20 && STATE != 2'd1; i++) begin
            if (CORE_EN) en_cnt++;
            nxt();
        end
        chk("step_en_cycles", 64'(en_cnt), 64'd5);
        chk("step_state_end", 64'(STATE), 64'd1);
        chk("step_cause",     64'(HALT_CAUSE), 64'd2);
        chk("step_cycle",     CYCLE_CNT, 64'd5);
        chk("step_remain",    64'(STEP_REMAIN), 64'd0);
        chk("step_coreen",    64'(CORE_EN), 64'd0);

        // RESET_CORE from HALTED clears the cycle count, then reload PC
        cmd(2'd3, 32'd0);
        pc_load = 1'b1; pc_init = 32'h0000_00F0;
        nxt();
        CMD_VALID = 1'b0; pc_load = 1'b0;
        #1;
        chk("rc_halted_state", 64'(STATE), 64'd0);
        chk("rc_halted_cycle", CYCLE_CNT, 64'd0);
        repeat (4) nxt();
        chk("rc_halted_back", 64'(STATE), 64'd1);

        // Breakpoint at 0x100 while running from 0xF0
        BP_EN = 1'b1; BP_ADDR = 32'h0000_0100;
        cmd(2'd1, 32'd0);
        nxt();
        CMD_VALID = 1'b0;
        #1;
        en_cnt = 0;
        for (int i = 0; i < 20 && STATE != 2'd1; i++) begin
            if (CORE_EN) en_cnt++;
            if (REGPC == 32'h100) chk("bp_en_drop", 64'(CORE_EN), 64'd0);
            nxt();
        end
        chk("bp_en_cycles", 64'(en_cnt), 64'd4);
        chk("bp_pc",        64'(REGPC), 64'h100);
        chk("bp_state",     64'(STATE), 64'd1);
        chk("bp_cause",     64'(HALT_CAUSE), 64'd3);
        chk("bp_cycle",     CYCLE_CNT, 64'd4);

        // Resume from the breakpoint PC: first cycle must not re-halt
        cmd(2'd1, 32'd0);
        nxt();
        CMD_VALID = 1'b0;
        #1;
        chk("resume_en_first", 64'(CORE_EN), 64'd1);
        nxt();
        chk("resume_pc",    64'(REGPC), 64'h104);
        chk("resume_state", 64'(STATE), 64'd2);
        chk("resume_en",    64'(CORE_EN), 64'd1);

        // HALT in the same cycle as a breakpoint hit: host halt wins
        BP_ADDR = 32'h0000_010C;
        nxt();
        nxt();
        chk("hb_pc", 64'(REGPC), 64'h10C);
        cmd(2'd0, 32'd0);
        #1;
        chk("hb_en", 64'(CORE_EN), 64'd0);
        nxt();
        CMD_VALID = 1'b0;
        #1;
        chk("hb_state", 64'(STATE), 64'd1);
        chk("hb_cause", 64'(HALT_CAUSE), 64'd1);

        // STEP with zero count is ignored
        cmd(2'd2, 32'd0);
        nxt();
        CMD_VALID = 1'b0;
        #1;
        chk("step0_state", 64'(STATE), 64'd1);
        chk("step0_en",    64'(CORE_EN), 64'd0);
        chk("step0_cause", 64'(HALT_CAUSE), 64'd1);
        nxt();
        chk("step0_en2", 64'(CORE_EN), 64'd0);

        // RESET_CORE during a STEP with 10 steps remaining
        BP_EN = 1'b0;
        cmd(2'd2, 32'd20);
        nxt();
        CMD_VALID = 1'b0;
        repeat (10) nxt();
        chk("rcs_remain", 64'(STEP_REMAIN), 64'd10);
        chk("rcs_state",  64'(STATE), 64'd3);
        cmd(2'd3, 32'd0);
        nxt();
        CMD_VALID = 1'b0;
        #1;
        chk("rcs_cycle",  CYCLE_CNT, 64'd0);
        chk("rcs_cause",  64'(HALT_CAUSE), 64'd0);
        chk("rcs_coreen", 64'(CORE_EN), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rcs_corerst", 64'(CORE_RST), 64'd1);
            chk("rcs_ready",   64'(CMD_READY), 64'd0);
            nxt();
        end
        chk("rcs_rel_corerst", 64'(CORE_RST), 64'd0);
        chk("rcs_rel_state",   64'(STATE), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_core_run_control.md
Name: cpu_core_run_control

Overview:
- Run/halt/step sequencer between the AXI-side core controller and the CPU core.
- Consumes the controller's core reset (CRST) and host commands; drives the core's reset and clock-enable.
- Monitors REGPC for a hardware breakpoint and counts executed cycles for the debug register window.
- Single clock domain (CCLK).

Parameters:
- RST_CYCLES, 4, number of CCLK cycles CORE_RST is held after any reset source (must be >= 1)
- CNT_WIDTH, 64, width of executed-cycle counter

Ports:
- CCLK  in  1  core clock
- CRST  in  1  synchronous active-high reset (from core controller)
- CMD_VALID  in  1  host command valid
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY
- CMD_OP  in  2  0=HALT, 1=RUN, 2=STEP, 3=RESET_CORE
- CMD_ARG  in  32  step count for STEP, ignored otherwise
- BP_EN  in  1  breakpoint enable
- BP_ADDR  in  32  breakpoint PC
- REGPC  in  32  current core PC
- CORE_RST  out  1  reset to CPU core, active-high
- CORE_EN  out  1  clock enable to CPU core (core advances on edges where CORE_EN=1)
- STATE  out  2  0=RSTSEQ, 1=HALTED, 2=RUN, 3=STEP
- HALT_CAUSE  out  2  0=reset, 1=host halt, 2=step done, 3=breakpoint
- STEP_REMAIN  out  32  remaining steps
- CYCLE_CNT  out  CNT_WIDTH  cycles with CORE_EN=1 since last reset

Behaviour:
- Reset is synchronous, active-high: CRST=1 at an edge gives the following register values:
  - STATE=RSTSEQ, rst counter=0, HALT_CAUSE=0, STEP_REMAIN=0, CYCLE_CNT=0, first flag=0.
- Combinational outputs during and after reset: CORE_RST=1, CORE_EN=0, CMD_READY=0.
- CORE_RST = (STATE==RSTSEQ), combinational from state register.
- RSTSEQ:
  - counter increments each cycle.
  - When counter==RST_CYCLES-1, go to HALTED at the next edge.
  - Result: CORE_RST is high for exactly RST_CYCLES cycles after CRST falls.
- CMD_READY = (STATE != RSTSEQ). Every command accepted outside RSTSEQ is consumed in one cycle.
- Breakpoint hit:
  - bp_hit = BP_EN && (REGPC==BP_ADDR) && !first.
  - first is set on the edge entering RUN/STEP and cleared after one cycle. This lets the core leave a PC equal to BP_ADDR.
- CORE_EN = (STATE==RUN || STATE==STEP) && !bp_hit, combinational. The core never advances past BP_ADDR.
- HALTED:
  - RUN: go to RUN, first=1.
  - STEP with CMD_ARG!=0: go to STEP, STEP_REMAIN=CMD_ARG, first=1.
  - STEP with CMD_ARG==0: ignored (no state or cause change).
  - HALT: no-op.
  - RESET_CORE: go to RSTSEQ, counter=0, CYCLE_CNT=0, HALT_CAUSE=0.
- RUN:
  - bp_hit: go to HALTED, cause=3.
  - Accepted HALT: go to HALTED, cause=1.
  - RESET_CORE: as above.
  - RUN or STEP commands: accepted and ignored.
- STEP:
  - Each cycle with CORE_EN=1, STEP_REMAIN decrements.
  - On a CORE_EN cycle with STEP_REMAIN==1: go to HALTED, cause=2, STEP_REMAIN=0.
  - bp_hit: go to HALTED, cause=3, STEP_REMAIN holds its value.
  - HALT: go to HALTED, cause=1, STEP_REMAIN holds its value.
  - RESET_CORE: as above.
- Priority in the same cycle: CRST > RESET_CORE > HALT > bp_hit > step completion.
- CYCLE_CNT increments on each edge where CORE_EN=1 and wraps at 2^CNT_WIDTH.
- REGPC is used unregistered. The upstream core must present a stable PC for the current instruction.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state encodings
  - CMD_OP codes (HALT/RUN/STEP/RESET_CORE)
  - HALT_CAUSE codes
- Those encodings are reused by the AXI controller's status register map.
- No sub-module. Counters and FSM live in one module.

Test Plan:
- CRST high 3 cycles, then low, RST_CYCLES=4 -> CORE_RST high exactly 4 cycles after CRST falls; STATE=1, HALT_CAUSE=0, CMD_READY=1 on 5th cycle.
- STEP with CMD_ARG=5 from HALTED -> CORE_EN high exactly 5 cycles; STATE returns to 1; HALT_CAUSE=2; CYCLE_CNT=5; STEP_REMAIN=0.
- BP_EN=1, BP_ADDR=0x100, RUN, model PC +4 per enable from 0xF0 -> CORE_EN drops in the cycle REGPC==0x100; HALT_CAUSE=3; CYCLE_CNT=4.
- From that halt (REGPC=0x100) issue RUN -> CORE_EN=1 in first cycle despite match; PC advances to 0x104; no immediate re-halt.
- RUN, then HALT in the same cycle as bp_hit -> HALT_CAUSE=1; STEP with CMD_ARG=0 in HALTED -> no state change, CORE_EN stays 0.
- RESET_CORE during STEP with STEP_REMAIN=10 -> CORE_RST high RST_CYCLES cycles; CYCLE_CNT=0; HALT_CAUSE=0; CMD_READY=0 during RSTSEQ.
